zle_xc3_decode: RTL and testbench



---
 rtl/zle_xc3_decode.sv | 105 ++++++++++
 tb/tb_zle_xc3_decode.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/zle_xc3_decode.sv
// Zero run-length decoder: expands literal / (0, count) tokens back into raw words.
// Optional count-word sanity check is enabled by defining ZLE_DECODE_CHECK_EN.
module zle_xc3_decode #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_v,
  output logic             i_b,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_v,
  input  logic             o_b,
  output logic [WIDTH-1:0] o_d,
  output logic             err
);

  typedef enum logic [1:0] {START, CNT, ZEROS} state_t;

  state_t            state, state_n;
  logic [CNTW-1:0]   cnt, cnt_n;
  logic              slot_free;
  logic              in_xfer;
  logic              load;
  logic [WIDTH-1:0]  load_d;

  assign slot_free = !o_v || !o_b;
  assign i_b       = !(slot_free && (state == START || state == CNT));
  assign in_xfer   = i_v && !i_b;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    load_d  = '0;
    unique case (state)
      START: begin
        if (in_xfer) begin
          if (i_d != '0) begin
            load   = 1'b1;
            load_d = i_d;
          end else begin
            state_n = CNT;
          end
        end
      end
      CNT: begin
        if (in_xfer) begin
          load = 1'b1;
          if (i_d[CNTW-1:0] == '0) begin
            state_n = START;
          end else begin
            cnt_n   = i_d[CNTW-1:0];
            state_n = ZEROS;
          end
        end
      end
      ZEROS: begin
        // cnt counts zeros still owed after the one emitted from CNT; it never reaches 0 here.
        if (slot_free) begin
          load  = 1'b1;
          cnt_n = cnt - 1'b1;
          if (cnt == CNTW'(1)) state_n = START;
        end
      end
      default: state_n = START;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= START;
      cnt   <= '0;
      o_v   <= 1'b0;
      o_d   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) begin
        o_v <= 1'b1;
        o_d <= load_d;
      end else if (o_v && !o_b) begin
        o_v <= 1'b0;
      end
    end
  end

`ifdef ZLE_DECODE_CHECK_EN
  logic err_r;

  // Sticky flag: a count word with any bit above the count field set is malformed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (state == CNT && in_xfer && i_d[WIDTH-1:CNTW] != '0) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_zle_xc3_decode.sv
// Directed self-checking bench for zle_xc3_decode (WIDTH=8, CNTW=4).
module tb_zle_xc3_decode;

  logic       clock;
  logic       reset;
  logic       i_v;
  logic       i_b;
  logic [7:0] i_d;
  logic       o_v;
  logic       o_b;
  logic [7:0] o_d;
  logic       err;

  int checks = 0;
  int errors = 0;
  int out_count = 0;
  int base;
  logic exp_err;

  zle_xc3_decode #(.WIDTH(8), .CNTW(4)) dut (
    .clock(clock),
    .reset(reset),
    .i_v(i_v),
    .i_b(i_b),
    .i_d(i_d),
    .o_v(o_v),
    .o_b(o_b),
    .o_d(o_d),
    .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counts words actually delivered to the consumer.
  always @(posedge clock) begin
    if (!reset && o_v && !o_b) out_count <= out_count + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic b);
    @(negedge clock);
    i_v = v;
    i_d = d;
    o_b = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
`ifdef ZLE_DECODE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    reset = 1'b1;
    i_v   = 1'b0;
    i_d   = 8'h00;
    o_b   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_o_v", 32'(o_v), 32'd0);
    checkOutput("reset_o_d", 32'(o_d), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_i_b", 32'(i_b), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Literals 5, 7, 9 back to back
    applyStimulus(1'b1, 8'd5, 1'b0);
    checkOutput("lit5_i_b", 32'(i_b), 32'd0);
    tick();
    checkOutput("lit5_o_v", 32'(o_v), 32'd1);
    checkOutput("lit5_o_d", 32'(o_d), 32'd5);
    applyStimulus(1'b1, 8'd7, 1'b0);
    checkOutput("lit7_i_b", 32'(i_b), 32'd0);
    tick();
    checkOutput("lit7_o_d", 32'(o_d), 32'd7);
    applyStimulus(1'b1, 8'd9, 1'b0);
    checkOutput("lit9_i_b", 32'(i_b), 32'd0);
    tick();
    checkOutput("lit9_o_d", 32'(o_d), 32'd9);
    applyStimulus(1'b0, 8'd0, 1'b0);
    tick();
    checkOutput("lit_drain_o_v", 32'(o_v), 32'd0);

    // Tokens 0,3,8 -> 0,0,0,0,8
    applyStimulus(1'b1, 8'd0, 1'b0);
    tick();
    checkOutput("run3_marker_o_v", 32'(o_v), 32'd0);
    applyStimulus(1'b1, 8'd3, 1'b0);
    checkOutput("run3_cnt_i_b", 32'(i_b), 32'd0);
    tick();
    checkOutput("run3_z1_o_v", 32'(o_v), 32'd1);
    checkOutput("run3_z1_o_d", 32'(o_d), 32'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'd8, 1'b0);
      checkOutput("run3_zeros_i_b", 32'(i_b), 32'd1);
      tick();
      checkOutput("run3_zn_o_v", 32'(o_v), 32'd1);
      checkOutput("run3_zn_o_d", 32'(o_d), 32'd0);
    end
    applyStimulus(1'b1, 8'd8, 1'b0);
    checkOutput("run3_lit_i_b", 32'(i_b), 32'd0);
    tick();
    checkOutput("run3_lit_o_d", 32'(o_d), 32'd8);
    applyStimulus(1'b0, 8'd0, 1'b0);
    tick();
    checkOutput("run3_drain_o_v", 32'(o_v), 32'd0);

    // Tokens 0,0 -> single zero; then 0,15 -> sixteen zeros
    applyStimulus(1'b1, 8'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'd0, 1'b0);
    tick();
    checkOutput("run0_o_v", 32'(o_v), 32'd1);
    checkOutput("run0_o_d", 32'(o_d), 32'd0);
    applyStimulus(1'b1, 8'd0, 1'b0);
    checkOutput("run0_back_start_i_b", 32'(i_b), 32'd0);
    tick();
    checkOutput("run15_marker_o_v", 32'(o_v), 32'd0);
    applyStimulus(1'b1, 8'd15, 1'b0);
    tick();
    checkOutput("run15_z1_o_v", 32'(o_v), 32'd1);
    for (int k = 0; k < 15; k++) begin
      applyStimulus(1'b0, 8'd0, 1'b0);
      checkOutput("run15_i_b", 32'(i_b), 32'd1);
      tick();
      checkOutput("run15_o_v", 32'(o_v), 32'd1);
      checkOutput("run15_o_d", 32'(o_d), 32'd0);
    end
    applyStimulus(1'b0, 8'd0, 1'b0);
    checkOutput("run15_end_i_b", 32'(i_b), 32'd0);
    tick();
    checkOutput("run15_end_o_v", 32'(o_v), 32'd0);

    // Run 0,5 with a three-cycle stall after the second zero
    applyStimulus(1'b0, 8'd0, 1'b0);
    base = out_count;
    applyStimulus(1'b1, 8'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'd5, 1'b0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("stall_i_b", 32'(i_b), 32'd1);
      tick();
      checkOutput("stall_o_v", 32'(o_v), 32'd1);
      checkOutput("stall_o_d", 32'(o_d), 32'd0);
    end
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 8'd0, 1'b0);
      tick();
    end
    checkOutput("stall_total_zeros", 32'(out_count - base), 32'd6);
    checkOutput("stall_end_o_v", 32'(o_v), 32'd0);

    // Asynchronous reset after 2 of 10 zeros
    applyStimulus(1'b1, 8'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'd9, 1'b0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0);
    tick();
    checkOutput("prereset_o_v", 32'(o_v), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_o_v", 32'(o_v), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1'b1, 8'd4, 1'b0);
    checkOutput("postreset_i_b", 32'(i_b), 32'd0);
    tick();
    checkOutput("postreset_o_v", 32'(o_v), 32'd1);
    checkOutput("postreset_o_d", 32'(o_d), 32'd4);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 8'd0, 1'b0);
      tick();
      checkOutput("postreset_no_residual_o_v", 32'(o_v), 32'd0);
    end

    // Malformed count word 0x12: low nibble gives 3 zeros
    base = out_count;
    applyStimulus(1'b1, 8'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h12, 1'b0);
    tick();
    checkOutput("malformed_err", 32'(err), 32'(exp_err));
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 8'd0, 1'b0);
      tick();
    end
    checkOutput("malformed_zeros", 32'(out_count - base), 32'd3);
    applyStimulus(1'b1, 8'd6, 1'b0);
    tick();
    checkOutput("malformed_next_o_d", 32'(o_d), 32'd6);
    checkOutput("malformed_err_sticky", 32'(err), 32'(exp_err));
    applyStimulus(1'b0, 8'd0, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("err_cleared_by_reset", 32'(err), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
